// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared pipeline types for the write-back / register-file slice
// Contents: DATA_W, ADDR_W, REG_NUM, REG_ZERO, word_t, regidx_t
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_NUM  = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regidx_t;

endpackage

// File: rtl/wb_select.sv
// rtl/wb_select.sv - write-back word mux (ALU result vs. memory data)
// Ports:
//   mem_to_reg : 1 selects mem_data, 0 selects alu_data
//   alu_data   : ALU result from MEM/WB
//   mem_data   : memory read data from MEM/WB
//   wb_data    : selected write-back word
module wb_select
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = mem_to_reg ? mem_data : alu_data;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back into a 2^ADDR_W x DATA_W register file with bypassed reads
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-low reset
//   RegWrite_i, MemtoReg_i        : MEM/WB write enable and write-back source select
//   mux0_i, mux1_i                : ALU result / memory data candidates
//   WriteBackPath_i               : destination register index
//   RSaddr_i/RSdata_o             : read port A
//   RTaddr_i/RTdata_o             : read port B
//   WBdata_o                      : selected write-back word (to forwarding unit)
//   WBcount_o                     : number of committed register writes (wraps)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] mux0_i,
    input  logic [DATA_W-1:0] mux1_i,
    input  logic [ADDR_W-1:0] WriteBackPath_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [31:0]       WBcount_o
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

    // Register 0 has no storage; only indices 1..NREG-1 are real flops.
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [31:0]       wb_count;
    logic [DATA_W-1:0] wb_data;
    logic              we;

    wb_select #(
        .DATA_W (DATA_W)
    ) u_wb_select (
        .mem_to_reg (MemtoReg_i),
        .alu_data   (mux0_i),
        .mem_data   (mux1_i),
        .wb_data    (wb_data)
    );

    assign WBdata_o  = wb_data;
    assign WBcount_o = wb_count;
    assign we        = RegWrite_i && (WriteBackPath_i != IDX_ZERO);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (we) begin
            regs[WriteBackPath_i] <= wb_data;
            wb_count              <= wb_count + 32'd1;
        end
    end

    // Write-first bypass; gated by rst_i so a write presented during reset
    // cannot leak onto the read ports while the array is held at zero.
    always_comb begin
        RSdata_o = '0;
        if (rst_i && (RSaddr_i != IDX_ZERO)) begin
            RSdata_o = (we && (RSaddr_i == WriteBackPath_i)) ? wb_data : regs[RSaddr_i];
        end
    end

    always_comb begin
        RTdata_o = '0;
        if (rst_i && (RTaddr_i != IDX_ZERO)) begin
            RTdata_o = (we && (RTaddr_i == WriteBackPath_i)) ? wb_data : regs[RTaddr_i];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [31:0] mux0 = '0;
    logic [31:0] mux1 = '0;
    logic [4:0]  wb_path = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_data, wb_count;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    wb_regfile dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .RegWrite_i      (reg_write),
        .MemtoReg_i      (mem_to_reg),
        .mux0_i          (mux0),
        .mux1_i          (mux1),
        .WriteBackPath_i (wb_path),
        .RSaddr_i        (rs_addr),
        .RTaddr_i        (rt_addr),
        .RSdata_o        (rs_data),
        .RTdata_o        (rt_data),
        .WBdata_o        (wb_data),
        .WBcount_o       (wb_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            n_total++;
            if ($isunknown(reg_write)) $display("FAIL regwrite_known got %b want 0/1", reg_write);
            else n_pass++;
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        reg_write = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            exp = exp_q.pop_front(); n_total++;
            if (rs_data !== exp) $display("FAIL reset_rs[%0d] got %h want %h", i, rs_data, exp); else n_pass++;
            exp = exp_q.pop_front(); n_total++;
            if (rt_data !== exp) $display("FAIL reset_rt[%0d] got %h want %h", 31 - i, rt_data, exp); else n_pass++;
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL reset_count got %h want %h", wb_count, exp); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b0;
        mux0 = 32'hDEADBEEF; mux1 = 32'h12345678;
        wb_path = 5'd5; rs_addr = 5'd5; rt_addr = 5'd6;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (wb_data !== exp) $display("FAIL bypass_wbdata got %h want %h", wb_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL bypass_rs got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL bypass_rt_other got %h want %h", rt_data, exp); else n_pass++;
        @(posedge clk); #1;
        reg_write = 1'b0;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL bypass_after_edge got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL bypass_count got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_zero_write();
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b1; mux1 = 32'hCAFEF00D;
        wb_path = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (wb_data !== exp) $display("FAIL zero_wbdata got %h want %h", wb_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL zero_rs_pre got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL zero_rt_pre got %h want %h", rt_data, exp); else n_pass++;
        @(posedge clk); #1;
        reg_write = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL zero_rs_post got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL zero_rt_post got %h want %h", rt_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL zero_count got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_no_write();
        @(negedge clk);
        reg_write = 1'b0; mem_to_reg = 1'b0; mux0 = 32'h1;
        wb_path = 5'd7; rs_addr = 5'd7; rt_addr = 5'd7;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL nowrite_no_bypass got %h want %h", rs_data, exp); else n_pass++;
        @(posedge clk); #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd1);
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL nowrite_reg7 got %h want %h", rt_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL nowrite_count got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_both_ports();
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b1; mux1 = 32'h0BADF00D; mux0 = 32'h11111111;
        wb_path = 5'd12; rs_addr = 5'd12; rt_addr = 5'd12;
        exp_q.push_back(32'h0BADF00D);
        exp_q.push_back(32'h0BADF00D);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL both_rs got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL both_rt got %h want %h", rt_data, exp); else n_pass++;
        @(negedge clk);
        reg_write = 1'b0; rt_addr = 5'd5;
        exp_q.push_back(32'h0BADF00D);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd2);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL both_rs_held got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL both_rt_reg5 got %h want %h", rt_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL both_count got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        reg_write = 1'b0;
        force dut.wb_count = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count;
        #1;
        reg_write = 1'b1; mem_to_reg = 1'b0; mux0 = 32'h3; wb_path = 5'd3;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        @(posedge clk); #1;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL wrap_first got %h want %h", wb_count, exp); else n_pass++;
        @(posedge clk); #1;
        reg_write = 1'b0;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL wrap_second got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b0; mux0 = 32'hA5A5A5A5; wb_path = 5'd9;
        rs_addr = 5'd9; rt_addr = 5'd9;
        @(posedge clk); #1;
        reg_write = 1'b0;
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL areset_pre got %h want %h", rs_data, exp); else n_pass++;
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL areset_rs got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (rt_data !== exp) $display("FAIL areset_rt got %h want %h", rt_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL areset_count got %h want %h", wb_count, exp); else n_pass++;
        // A write presented while reset is held must not leak through the bypass
        // and must commit at the first edge after release.
        @(negedge clk);
        reg_write = 1'b1; mux0 = 32'h4444_0004; wb_path = 5'd4; rs_addr = 5'd4;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL areset_bypass_held got %h want %h", rs_data, exp); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        reg_write = 1'b0;
        exp_q.push_back(32'h4444_0004);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); n_total++;
        if (rs_data !== exp) $display("FAIL areset_first_commit got %h want %h", rs_data, exp); else n_pass++;
        exp = exp_q.pop_front(); n_total++;
        if (wb_count !== exp) $display("FAIL areset_first_count got %h want %h", wb_count, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [32];
        logic [31:0] exp_cnt;
        logic [31:0] wbv;
        logic        we_m;
        @(negedge clk);
        reg_write = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        exp_cnt = 32'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            reg_write  = ($urandom_range(0, 3) != 0);
            mem_to_reg = 1'($urandom_range(0, 1));
            mux0       = $urandom;
            mux1       = $urandom;
            wb_path    = 5'($urandom_range(0, 31));
            rs_addr    = ($urandom_range(0, 2) == 0) ? wb_path : 5'($urandom_range(0, 31));
            rt_addr    = ($urandom_range(0, 2) == 0) ? wb_path : 5'($urandom_range(0, 31));
            wbv  = mem_to_reg ? mux1 : mux0;
            we_m = reg_write && (wb_path != 5'd0);
            exp_q.push_back(wbv);
            exp_q.push_back((rs_addr == 5'd0) ? 32'h0 : (we_m && rs_addr == wb_path) ? wbv : model[rs_addr]);
            exp_q.push_back((rt_addr == 5'd0) ? 32'h0 : (we_m && rt_addr == wb_path) ? wbv : model[rt_addr]);
            exp_q.push_back(exp_cnt);
            #1;
            exp = exp_q.pop_front(); n_total++;
            if (wb_data !== exp) $display("FAIL b2b_wbdata c%0d got %h want %h", c, wb_data, exp); else n_pass++;
            exp = exp_q.pop_front(); n_total++;
            if (rs_data !== exp) $display("FAIL b2b_rs c%0d idx %0d got %h want %h", c, rs_addr, rs_data, exp); else n_pass++;
            exp = exp_q.pop_front(); n_total++;
            if (rt_data !== exp) $display("FAIL b2b_rt c%0d idx %0d got %h want %h", c, rt_addr, rt_data, exp); else n_pass++;
            exp = exp_q.pop_front(); n_total++;
            if (wb_count !== exp) $display("FAIL b2b_count c%0d got %h want %h", c, wb_count, exp); else n_pass++;
            @(posedge clk);
            if (we_m) begin
                model[wb_path] = wbv;
                exp_cnt = exp_cnt + 32'd1;
            end
        end
        @(negedge clk);
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            exp_q.push_back(model[i]);
            #1;
            exp = exp_q.pop_front(); n_total++;
            if (rs_data !== exp) $display("FAIL b2b_final reg %0d got %h want %h", i, rs_data, exp); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_write();
        test_no_write();
        test_both_ports();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
